// File: rtl/uart_key_tx_scheduler.sv
// Purpose: round-robin scheduler sharing one UART transmitter among keys a/s/d/w; auto-repeat enabled by `TX_SCHED_REPEAT_EN.
// Latency: key rise sampled at edge N sets pending at N; when idle, o_tx_start pulses from edge N+1 for one cycle.
// Backpressure: one frame in flight; waits for i_tx_busy to rise then fall, then GAP_CLOCKS idle clocks; presses on pending keys pulse o_overrun.
module uart_key_tx_scheduler #(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] CODE_A        = 'h61,
    parameter logic [DATA_WIDTH-1:0] CODE_S        = 'h73,
    parameter logic [DATA_WIDTH-1:0] CODE_D        = 'h64,
    parameter logic [DATA_WIDTH-1:0] CODE_W        = 'h77,
    parameter int                    GAP_CLOCKS    = 434,
    parameter int                    ACK_TIMEOUT   = 4,
    parameter int                    REPEAT_CLOCKS = 1608997,
    parameter int                    COUNTER_WIDTH = 21
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [3:0]            i_key,
    input  logic                  i_tx_busy,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [3:0]            o_grant,
    output logic [3:0]            o_pending,
    output logic                  o_overrun,
    output logic                  o_error
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_ACK  = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    localparam logic [COUNTER_WIDTH-1:0] ACK_LAST = COUNTER_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [COUNTER_WIDTH-1:0] GAP_LAST = COUNTER_WIDTH'(GAP_CLOCKS - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    // Both periods share the counter width; a too-narrow counter would wrap silently.
    if (GAP_CLOCKS >= (1 << COUNTER_WIDTH) || REPEAT_CLOCKS >= (1 << COUNTER_WIDTH)) begin : g_bad_counter_width
        $error("COUNTER_WIDTH cannot hold GAP_CLOCKS or REPEAT_CLOCKS");
    end

    logic [3:0]               key_prev_q;
    logic [3:0]               rise;
    logic [3:0]               rep_fire;
    logic [3:0]               set_req;
    logic [3:0]               clr;
    logic [3:0]               pend_q, pend_d;
    logic                     ovr_q, ovr_d;
    logic [1:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]               ptr_q, ptr_d;
    logic                     start_q, start_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [3:0]               grant_q, grant_d;
    logic                     err_q, err_d;
    logic                     win_found;
    logic [1:0]               win_idx;
    logic [1:0]               cand;

    function automatic logic [DATA_WIDTH-1:0] code_of(input logic [1:0] idx);
        case (idx)
            2'd0:    code_of = CODE_A;
            2'd1:    code_of = CODE_S;
            2'd2:    code_of = CODE_D;
            default: code_of = CODE_W;
        endcase
    endfunction

    assign rise = i_key & ~key_prev_q;

`ifdef TX_SCHED_REPEAT_EN
    localparam logic [COUNTER_WIDTH-1:0] REP_LAST = COUNTER_WIDTH'(REPEAT_CLOCKS - 1);
    logic [COUNTER_WIDTH-1:0] rep_cnt_q [4];
    logic [COUNTER_WIDTH-1:0] rep_cnt_d [4];

    // Hold timers: restart on press, clear on release, fire and restart every REPEAT_CLOCKS while held.
    always_comb begin
        rep_fire = '0;
        for (int k = 0; k < 4; k++) begin
            rep_cnt_d[k] = rep_cnt_q[k] + CNT_ONE;
            if (!i_key[k] || rise[k]) begin
                rep_cnt_d[k] = '0;
            end else if (rep_cnt_q[k] == REP_LAST) begin
                rep_cnt_d[k] = '0;
                rep_fire[k]  = 1'b1;
            end
        end
    end

    // Register the hold timers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < 4; k++) rep_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) rep_cnt_q[k] <= rep_cnt_d[k];
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign set_req = rise | rep_fire;

    // A new request wins over a same-cycle grant clear; any request on an already-pending key is one overrun.
    always_comb begin
        pend_d = (pend_q & ~clr) | set_req;
        ovr_d  = |(set_req & pend_q);
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && pend_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Transmission sequencing: grant, wait for busy, wait for done, enforce the inter-frame gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        start_d = 1'b0;
        data_d  = data_q;
        grant_d = grant_q;
        err_d   = 1'b0;
        clr     = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    start_d = 1'b1;
                    data_d  = code_of(win_idx);
                    grant_d = 4'b0001 << win_idx;
                    clr     = 4'b0001 << win_idx;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == ACK_LAST) begin
                    // Transmitter never answered: drop this request rather than retry it.
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    cnt_d = '0;
                    if (GAP_CLOCKS == 0) begin
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            default: begin
                if (cnt_q == GAP_LAST) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Key history, pending flags and overrun pulse.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            key_prev_q <= '0;
            pend_q     <= '0;
            ovr_q      <= 1'b0;
        end else begin
            key_prev_q <= i_key;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
        end
    end

    // Scheduler state and registered transmitter-facing outputs; pointer resets to 3 so key a goes first.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
            start_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;
    assign o_grant    = grant_q;
    assign o_pending  = pend_q;
    assign o_overrun  = ovr_q;
    assign o_error    = err_q;

endmodule

// File: tb/tb_uart_key_tx_scheduler.sv
// Bench for uart_key_tx_scheduler: table vectors, directed corner sequences and random key traffic
// against a transaction-level model (pending set, round-robin pick, gap and timeout timing).
// Runs with or without TX_SCHED_REPEAT_EN defined.
module tb_uart_key_tx_scheduler;

    localparam int GAP  = 5;
    localparam int ACK  = 4;
    localparam int REP  = 50;
`ifdef TX_SCHED_REPEAT_EN
    localparam int EXP_REP_STARTS = 4;
`else
    localparam int EXP_REP_STARTS = 1;
`endif

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [3:0] i_key = '0;
    logic       i_tx_busy = 1'b0;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic [3:0] o_grant;
    logic [3:0] o_pending;
    logic       o_overrun;
    logic       o_error;

    uart_key_tx_scheduler #(
        .DATA_WIDTH(8), .GAP_CLOCKS(GAP), .ACK_TIMEOUT(ACK),
        .REPEAT_CLOCKS(REP), .COUNTER_WIDTH(21)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_key(i_key), .i_tx_busy(i_tx_busy),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_grant(o_grant),
        .o_pending(o_pending), .o_overrun(o_overrun), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] log_q [$];
    int         ovr_cnt = 0;
    int         err_cnt = 0;
    bit         never_busy = 0;
    bit         rand_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] key_code(input int k);
        case (k)
            0:       return 8'h61;
            1:       return 8'h73;
            2:       return 8'h64;
            default: return 8'h77;
        endcase
    endfunction

    function automatic int rr_pick(input logic [3:0] pend, input int ptr);
        int w;
        w = -1;
        for (int i = 1; i <= 4; i++)
            if (w < 0 && pend[(ptr + i) % 4]) w = (ptr + i) % 4;
        return w;
    endfunction

    // Transmitter model: busy rises the clock after it sees a start, holds for a frame length.
    int bcnt = 0;
    bit armed = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (i_reset) begin
                i_tx_busy = 1'b0; bcnt = 0; armed = 0;
            end else begin
                if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) i_tx_busy = 1'b0;
                end else if (armed) begin
                    armed = 0;
                    i_tx_busy = 1'b1;
                    bcnt = rand_len ? $urandom_range(1, 12) : 10;
                end
                if (o_tx_start && !never_busy && !(rand_len && $urandom_range(0, 7) == 0)) armed = 1;
            end
        end
    end

    // Reference model state.
    logic [3:0] m_pend, m_prev, m_set, m_clr, m_before, k_e;
    int         m_ptr, m_cyc, m_start_edge, m_fall_edge, m_w;
    bit         m_in_flight, m_fall_valid, m_pend_at_fall, m_b_prev, m_start_prev, m_exp_err;
    bit         rst_e, b_e;
    int         m_held [4];

    task automatic model_init();
        m_pend = '0; m_prev = '0; m_ptr = 3; m_in_flight = 0; m_fall_valid = 0;
        m_pend_at_fall = 0; m_b_prev = 0; m_start_prev = 0;
        for (int k = 0; k < 4; k++) m_held[k] = 0;
    endtask

    // Monitor: keys/busy taken at the active edge, outputs checked at the falling edge.
    initial begin
        model_init();
        m_cyc = 0;
        forever begin
            @(posedge clk);
            m_cyc++;
            rst_e = i_reset; k_e = i_key; b_e = i_tx_busy;
            @(negedge clk);
            if (rst_e || i_reset) begin
                model_init();
                continue;
            end
            if (m_b_prev && !b_e) begin
                m_fall_edge = m_cyc; m_fall_valid = 1; m_pend_at_fall = (m_pend != 0);
            end
            m_b_prev = b_e;
            if (m_in_flight && b_e) m_in_flight = 0;
            m_before = m_pend;
            m_clr = '0;
            if (o_tx_start) begin
                chk("start_single_cycle", 32'(m_start_prev), 0);
                chk("start_has_pending", 32'(m_before != 0), 1);
                m_w = rr_pick(m_before, m_ptr);
                if (m_w >= 0) begin
                    chk("start_grant", 32'(o_grant), 32'(4'b0001 << m_w));
                    chk("start_data", 32'(o_tx_data), 32'(key_code(m_w)));
                    if (m_fall_valid) begin
                        if (m_pend_at_fall) chk("gap_exact", m_cyc - m_fall_edge, GAP + 1);
                        else chk("gap_min", 32'((m_cyc - m_fall_edge) >= GAP + 1), 1);
                    end
                    m_fall_valid = 0;
                    m_clr = 4'b0001 << m_w;
                    m_ptr = m_w;
                    m_start_edge = m_cyc;
                    m_in_flight = 1;
                    log_q.push_back(o_tx_data);
                end
            end
            m_start_prev = o_tx_start;
            m_exp_err = m_in_flight && (m_cyc == m_start_edge + ACK);
            chk("error_pulse", 32'(o_error), 32'(m_exp_err));
            if (m_exp_err) begin
                chk("grant_after_error", 32'(o_grant), 0);
                m_in_flight = 0;
            end
            if (o_error) err_cnt++;
            m_set = k_e & ~m_prev;
`ifdef TX_SCHED_REPEAT_EN
            for (int k = 0; k < 4; k++) begin
                if (!k_e[k] || m_set[k]) m_held[k] = 0;
                else begin
                    m_held[k]++;
                    if (m_held[k] == REP) begin m_set[k] = 1'b1; m_held[k] = 0; end
                end
            end
`endif
            chk("overrun", 32'(o_overrun), 32'(|(m_set & m_before)));
            if (o_overrun) ovr_cnt++;
            m_pend = (m_before & ~m_clr) | m_set;
            chk("pending", 32'(o_pending), 32'(m_pend));
            m_prev = k_e;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        i_key = '0;
        i_reset = 1'b1;
        #2;
        chk("reset_outputs", 32'({o_tx_start, o_tx_data, o_grant, o_pending, o_overrun, o_error}), 0);
        tick(3);
        i_reset = 1'b0;
        log_q.delete();
        ovr_cnt = 0; err_cnt = 0;
        tick(2);
    endtask

    task automatic press(input logic [3:0] keys, input int hold = 2);
        i_key = i_key | keys;
        tick(hold);
        i_key = i_key & ~keys;
    endtask

    task automatic wait_log(input int n, input int budget);
        int t;
        t = 0;
        while (log_q.size() < n && t < budget) begin tick(); t++; end
    endtask

    typedef struct packed {
        logic [3:0]  keys;
        logic [2:0]  n;
        logic [31:0] codes;
    } vec_t;
    vec_t vecs [6];

    initial begin
        vecs[0] = '{keys: 4'b0010, n: 3'd1, codes: 32'h00000073};
        vecs[1] = '{keys: 4'b1111, n: 3'd4, codes: 32'h77647361};
        vecs[2] = '{keys: 4'b1100, n: 3'd2, codes: 32'h00007764};
        vecs[3] = '{keys: 4'b1001, n: 3'd2, codes: 32'h00007761};
        vecs[4] = '{keys: 4'b0000, n: 3'd0, codes: 32'h00000000};
        vecs[5] = '{keys: 4'b0101, n: 3'd2, codes: 32'h00006461};

        tick();
        // Table vectors: from reset, one burst of presses, expected transmission order.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            press(vecs[v].keys, 2);
            wait_log(int'(vecs[v].n), 300);
            tick(40);
            chk($sformatf("vec%0d_count", v), log_q.size(), int'(vecs[v].n));
            for (int i = 0; i < int'(vecs[v].n); i++)
                if (i < log_q.size()) chk($sformatf("vec%0d_code%0d", v, i), 32'(log_q[i]), 32'(vecs[v].codes[8*i +: 8]));
            chk($sformatf("vec%0d_idle_grant", v), 32'(o_grant), 0);
            chk($sformatf("vec%0d_idle_pending", v), 32'(o_pending), 0);
        end

        // Pointer follows the last winner: d, then a+w raised while busy -> w before a.
        do_reset();
        press(4'b0100, 2);
        wait_log(1, 50);
        tick(3);
        press(4'b1001, 2);
        wait_log(3, 200);
        tick(40);
        chk("rr_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("rr_first_d", 32'(log_q[0]), 32'h64);
            chk("rr_then_w", 32'(log_q[1]), 32'h77);
            chk("rr_then_a", 32'(log_q[2]), 32'h61);
        end

        // Second press of s while s still pending: one overrun, one transmission of s.
        do_reset();
        press(4'b0100, 2);
        wait_log(1, 50);
        tick(1);
        press(4'b0010, 2);
        tick(2);
        press(4'b0010, 2);
        wait_log(2, 200);
        tick(40);
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_tx_count", log_q.size(), 2);
        if (log_q.size() == 2) chk("ovr_s_sent", 32'(log_q[1]), 32'h73);

        // Transmitter never answers: timeout error, request dropped, scheduler usable afterwards.
        do_reset();
        never_busy = 1;
        press(4'b1000, 2);
        wait_log(1, 50);
        tick(10);
        chk("timeout_errors", err_cnt, 1);
        chk("timeout_grant", 32'(o_grant), 0);
        chk("timeout_pending", 32'(o_pending), 0);
        never_busy = 0;
        press(4'b0001, 2);
        wait_log(2, 50);
        tick(40);
        chk("after_timeout_count", log_q.size(), 2);
        if (log_q.size() == 2) chk("after_timeout_a", 32'(log_q[1]), 32'h61);
        chk("after_timeout_errors", err_cnt, 1);

        // Reset mid-transmission drops the in-flight grant and the waiting request.
        do_reset();
        press(4'b0011, 2);
        wait_log(1, 50);
        tick(3);
        do_reset();
        tick(30);
        chk("reset_drops_pending", log_q.size(), 0);

        // Holding a for 175 clocks.
        do_reset();
        i_key = 4'b0001;
        tick(175);
        i_key = '0;
        tick(60);
        chk("hold_a_starts", log_q.size(), EXP_REP_STARTS);
        for (int i = 0; i < log_q.size(); i++) chk("hold_a_code", 32'(log_q[i]), 32'h61);

        // Random key traffic with random frame lengths and occasional silent transmitter.
        do_reset();
        rand_len = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) i_key = 4'($urandom_range(0, 15));
            tick();
        end
        i_key = '0;
        tick(200);
        rand_len = 0;
        chk("random_drained_grant", 32'(o_grant), 0);
        chk("random_drained_pending", 32'(o_pending), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
